ps2_key_sequencer: RTL and testbench

- Synchronous PS/2 keyboard front-end controller, clocked by the system clock, sampling the raw PS2CLK/PS2Data pins.
- Sequences frame reception (start, 8 data, parity, stop) and checks framing and parity.
- Tracks E0/F0/E1 prefix state and queues complete key events {ext, break, code} in a small FIFO with a valid/ready handshake for the game logic.
- Replaces free-running shift-register capture in the PS2CLK domain with one-clock-domain sequencing.

---
 rtl/ps2_key_sequencer.sv | 240 ++++++++++++++++++++++++
 tb/tb_ps2_key_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ps2_key_sequencer
// Purpose  : PS/2 keyboard front-end. It samples the raw pins on the system
//            clock, decodes and checks frames, folds E0/F0/E1 prefixes into
//            events, and queues {ext, break, code} for the consumer.
// Options  : PS2_DIR_DECODE_EN adds the Dir/DirUpd direction decoder.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_key_sequencer #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 20000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic       PS2CLK,
    input  logic       PS2Data,
    output logic [7:0] KeyCode,
    output logic       KeyExt,
    output logic       KeyBreak,
    output logic       KeyValid,
    input  logic       KeyReady,
    output logic       FrameErr,
    output logic       Overflow,
`ifdef PS2_DIR_DECODE_EN
    output logic [1:0] Dir,
    output logic       DirUpd,
`endif
    output logic       Busy
);

    localparam int c_FW = $clog2(FILTER_LEN + 1);
    localparam int c_TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int c_AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic [1:0]      r_clk_sync, r_dat_sync;
    logic [c_FW-1:0] r_flt_cnt;
    logic            r_clk_flt, r_strobe;
    state_t          r_state, w_state_nxt;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_shift, r_byte;
    logic            r_par, r_byte_vld, r_ferr, r_ovf;
    logic [c_TW-1:0] r_tmo;
    logic            w_timeout, w_accept, w_ferr, w_dat;
    logic            r_ext, r_brk;
    logic [2:0]      r_e1_cnt;
    logic            w_push, w_pop, w_full, w_wr, w_ovf;
    logic [9:0]      w_push_data, r_head, w_head_nxt;
    logic [9:0]      r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_rd_ptr, r_wr_ptr;
    logic [c_AW:0]   r_count, w_cnt_left;

    assign w_dat = r_dat_sync[1];

    // Filtered clock only flips after FILTER_LEN agreeing samples; the strobe
    // marks the filtered 1->0 transition.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
            r_flt_cnt  <= '0;
            r_clk_flt  <= 1'b1;
            r_strobe   <= 1'b0;
        end else begin
            r_clk_sync <= {r_clk_sync[0], PS2CLK};
            r_dat_sync <= {r_dat_sync[0], PS2Data};
            r_strobe   <= 1'b0;
            if (r_clk_sync[1] == r_clk_flt) begin
                r_flt_cnt <= '0;
            end else if (r_flt_cnt == c_FW'(FILTER_LEN - 1)) begin
                r_flt_cnt <= '0;
                r_clk_flt <= r_clk_sync[1];
                r_strobe  <= r_clk_flt;
            end else begin
                r_flt_cnt <= r_flt_cnt + 1'b1;
            end
        end
    end

    assign w_timeout = (r_state != S_IDLE) && !r_strobe
                       && (r_tmo == c_TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_ferr      = 1'b0;
        case (r_state)
            S_IDLE:   if (r_strobe && !w_dat) w_state_nxt = S_DATA;
            S_DATA:   if (r_strobe && (r_bit_cnt == 3'd7)) w_state_nxt = S_PARITY;
            S_PARITY: if (r_strobe) w_state_nxt = S_STOP;
            S_STOP: begin
                if (r_strobe) begin
                    w_state_nxt = S_IDLE;
                    if (w_dat && (^{r_shift, r_par})) w_accept = 1'b1;
                    else                               w_ferr   = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_timeout) begin
            w_state_nxt = S_IDLE;
            w_ferr      = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_tmo      <= '0;
            r_byte     <= '0;
            r_byte_vld <= 1'b0;
            r_ferr     <= 1'b0;
        end else begin
            r_byte_vld <= w_accept;
            r_ferr     <= w_ferr;
            if (w_accept) r_byte <= r_shift;
            if (r_strobe || (r_state == S_IDLE)) r_tmo <= '0;
            else                                 r_tmo <= r_tmo + 1'b1;
            if (r_strobe) begin
                if (r_state == S_IDLE) r_bit_cnt <= '0;
                if (r_state == S_DATA) begin
                    r_shift   <= {w_dat, r_shift[7:1]};
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
                if (r_state == S_PARITY) r_par <= w_dat;
            end
        end
    end

    // Prefix bytes only update flags; the E1 pause sequence swallows 7 more bytes.
    assign w_push = r_byte_vld && (r_e1_cnt == 3'd0) && (r_byte != 8'hE0)
                    && (r_byte != 8'hF0) && (r_byte != 8'hE1);
    assign w_push_data = {r_ext, r_brk, r_byte};

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_ext    <= 1'b0;
            r_brk    <= 1'b0;
            r_e1_cnt <= '0;
        end else if (w_timeout) begin
            r_ext    <= 1'b0;
            r_brk    <= 1'b0;
            r_e1_cnt <= '0;
        end else if (r_byte_vld) begin
            if (r_e1_cnt != 3'd0)    r_e1_cnt <= r_e1_cnt - 1'b1;
            else if (r_byte == 8'hE1) r_e1_cnt <= 3'd7;
            else if (r_byte == 8'hE0) r_ext    <= 1'b1;
            else if (r_byte == 8'hF0) r_brk    <= 1'b1;
            else begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end
        end
    end

    assign KeyValid = (r_count != '0);
    assign w_pop    = KeyValid && KeyReady;
    assign w_full   = (r_count == (c_AW + 1)'(FIFO_DEPTH));
    assign w_wr     = w_push && (!w_full || w_pop);
    assign w_ovf    = w_push && w_full && !w_pop;

    // Head register is preloaded so a push into an empty FIFO is visible next cycle.
    always_comb begin
        w_head_nxt = r_head;
        w_cnt_left = r_count - {{c_AW{1'b0}}, w_pop};
        if (w_cnt_left != '0) w_head_nxt = r_mem[r_rd_ptr + c_AW'(w_pop)];
        else if (w_wr)        w_head_nxt = w_push_data;
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_ovf   <= w_ovf;
            r_head  <= w_head_nxt;
            r_count <= r_count + {{c_AW{1'b0}}, w_wr} - {{c_AW{1'b0}}, w_pop};
            if (w_wr) begin
                r_mem[r_wr_ptr] <= w_push_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    assign KeyCode  = r_head[7:0];
    assign KeyBreak = r_head[8];
    assign KeyExt   = r_head[9];
    assign FrameErr = r_ferr;
    assign Overflow = r_ovf;
    assign Busy     = (r_state != S_IDLE);

`ifdef PS2_DIR_DECODE_EN
    logic [1:0] r_dir, w_dir_new;
    logic       r_dir_upd, w_dir_hit;

    always_comb begin
        w_dir_hit = 1'b0;
        w_dir_new = r_dir;
        if (w_push && !r_brk) begin
            case ({r_ext, r_byte})
                9'h175, 9'h01D: begin w_dir_hit = 1'b1; w_dir_new = 2'b00; end
                9'h172, 9'h01B: begin w_dir_hit = 1'b1; w_dir_new = 2'b01; end
                9'h16B, 9'h01C: begin w_dir_hit = 1'b1; w_dir_new = 2'b10; end
                9'h174, 9'h023: begin w_dir_hit = 1'b1; w_dir_new = 2'b11; end
                default:        w_dir_hit = 1'b0;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_dir     <= 2'b00;
            r_dir_upd <= 1'b0;
        end else begin
            r_dir_upd <= w_dir_hit && (w_dir_new != r_dir);
            if (w_dir_hit) r_dir <= w_dir_new;
        end
    end

    assign Dir    = r_dir;
    assign DirUpd = r_dir_upd;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_sequencer.sv
`default_nettype none
// Testbench for ps2_key_sequencer: bit-banged PS/2 frames checked against a
// queue-based model of prefix decoding and event buffering.
module tb_ps2_key_sequencer;
    localparam int DEPTH = 4;
    localparam int TMO   = 20000;
    localparam int HALF  = 8;

    logic       CLK = 1'b0, RSTN = 1'b0, PS2CLK = 1'b1, PS2Data = 1'b1, KeyReady = 1'b0;
    logic [7:0] KeyCode;
    logic       KeyExt, KeyBreak, KeyValid, FrameErr, Overflow, Busy;
`ifdef PS2_DIR_DECODE_EN
    logic [1:0] Dir;
    logic       DirUpd;
`endif

    int         checks = 0, errors = 0;
    int         ferr_cnt = 0, ovf_cnt = 0, dirupd_cnt = 0;
    logic [9:0] exp_q[$], got_q[$];
    bit         m_ext = 0, m_brk = 0, cap_en = 0;
    int         m_e1 = 0, m_occ = 0, exp_ovf = 0;

    ps2_key_sequencer #(.FILTER_LEN(4), .TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(DEPTH)) dut (
        .CLK(CLK), .RSTN(RSTN), .PS2CLK(PS2CLK), .PS2Data(PS2Data),
        .KeyCode(KeyCode), .KeyExt(KeyExt), .KeyBreak(KeyBreak), .KeyValid(KeyValid),
        .KeyReady(KeyReady), .FrameErr(FrameErr), .Overflow(Overflow),
`ifdef PS2_DIR_DECODE_EN
        .Dir(Dir), .DirUpd(DirUpd),
`endif
        .Busy(Busy)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (FrameErr) ferr_cnt++;
        if (Overflow) ovf_cnt++;
`ifdef PS2_DIR_DECODE_EN
        if (DirUpd) dirupd_cnt++;
`endif
        if (KeyValid && KeyReady) got_q.push_back({KeyExt, KeyBreak, KeyCode});
    end

    // Keyboard protocol as seen by the consumer: prefixes accumulate, E1 eats 7 more.
    function automatic void model_byte(input logic [7:0] b);
        if (m_e1 > 0) m_e1--;
        else if (b == 8'hE1) m_e1 = 7;
        else if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else begin
            if (cap_en && m_occ >= DEPTH) exp_ovf++;
            else begin
                exp_q.push_back({m_ext, m_brk, b});
                m_occ++;
            end
            m_ext = 0;
            m_brk = 0;
        end
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic ps2_bit(input logic v);
        PS2Data = v;
        tick(HALF);
        PS2CLK = 1'b0;
        tick(HALF);
        PS2CLK = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input bit track);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
        if (track && !bad_par && !bad_stop) model_byte(b);
        ps2_bit(!bad_stop);
        PS2Data = 1'b1;
        tick(2 * HALF);
    endtask

    function automatic logic [7:0] rand_make();
        logic [7:0] b;
        do b = 8'($urandom_range(1, 255)); while (b == 8'hE0 || b == 8'hF0 || b == 8'hE1);
        return b;
    endfunction

    task automatic clear_queues();
        exp_q.delete();
        got_q.delete();
        m_occ = 0;
    endtask

    task automatic test_reset();
        RSTN = 1'b0;
        tick(4);
        RSTN = 1'b1;
        tick(2);
        checks++; if (KeyCode !== 8'h00) begin errors++; $display("FAIL reset_keycode: got %h, required 00", KeyCode); end
        checks++; if (KeyExt !== 1'b0) begin errors++; $display("FAIL reset_ext: got %b, required 0", KeyExt); end
        checks++; if (KeyBreak !== 1'b0) begin errors++; $display("FAIL reset_break: got %b, required 0", KeyBreak); end
        checks++; if (KeyValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", KeyValid); end
        checks++; if (FrameErr !== 1'b0) begin errors++; $display("FAIL reset_frameerr: got %b, required 0", FrameErr); end
        checks++; if (Overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b, required 0", Overflow); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", Busy); end
    endtask

    // KeyValid must rise exactly one cycle after Busy falls (two after the stop strobe).
    task automatic test_latency();
        int n;
        clear_queues();
        n = 0;
        fork
            send_frame(8'h1C, 0, 0, 0);
            begin
                while (Busy !== 1'b1 && n < 2000) begin @(negedge CLK); n++; end
                while (Busy !== 1'b0 && n < 4000) begin @(negedge CLK); n++; end
                checks++;
                if (n >= 4000 || KeyValid !== 1'b0) begin
                    errors++; $display("FAIL latency_early: got valid=%b cycles=%0d, required valid=0", KeyValid, n);
                end
                @(negedge CLK);
                checks++;
                if ({KeyValid, KeyExt, KeyBreak, KeyCode} !== {1'b1, 1'b0, 1'b0, 8'h1C}) begin
                    errors++; $display("FAIL latency_head: got %b/%b/%b/%h, required 1/0/0/1c", KeyValid, KeyExt, KeyBreak, KeyCode);
                end
            end
        join
        KeyReady = 1'b1;
        tick(1);
        KeyReady = 1'b0;
        @(negedge CLK);
        checks++; if (KeyValid !== 1'b0) begin errors++; $display("FAIL latency_pop: got valid=%b, required 0", KeyValid); end
        checks++; if (KeyCode !== 8'h1C) begin errors++; $display("FAIL latency_hold: got %h, required 1c", KeyCode); end
        tick(1);
    endtask

    task automatic test_prefix();
        int f0;
        clear_queues();
        f0 = ferr_cnt;
        KeyReady = 1'b1;
        send_frame(8'hE0, 0, 0, 1);
        send_frame(8'hF0, 0, 0, 1);
        send_frame(8'h75, 0, 0, 1);
        send_frame(8'h1C, 0, 0, 1);
        tick(10);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL prefix_count: got %0d events, required %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL prefix_event%0d: got %h, required %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (ferr_cnt != f0) begin errors++; $display("FAIL prefix_ferr: got %0d pulses, required 0", ferr_cnt - f0); end
    endtask

    task automatic test_frame_errors();
        int f0;
        for (int k = 0; k < 2; k++) begin
            clear_queues();
            f0 = ferr_cnt;
            KeyReady = 1'b1;
            send_frame(8'h1C, k == 0, k == 1, 1);
            send_frame(8'h1B, 0, 0, 1);
            tick(10);
            checks++; if (ferr_cnt - f0 != 1) begin errors++; $display("FAIL err%0d_pulses: got %0d, required 1", k, ferr_cnt - f0); end
            checks++; if (got_q.size() != 1 || got_q[0] !== 10'h01B) begin
                errors++; $display("FAIL err%0d_event: got %0d events head %h, required 1 event 01b", k, got_q.size(), got_q.size() > 0 ? got_q[0] : 10'h0);
            end
        end
    endtask

    task automatic test_timeout();
        int f0;
        clear_queues();
        KeyReady = 1'b1;
        send_frame(8'hE0, 0, 0, 1);
        f0 = ferr_cnt;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(i[0]);
        PS2Data = 1'b1;
        tick(TMO + 100);
        m_ext = 0; m_brk = 0; m_e1 = 0;
        checks++; if (ferr_cnt - f0 != 1) begin errors++; $display("FAIL timeout_pulse: got %0d, required 1", ferr_cnt - f0); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL timeout_busy: got %b, required 0", Busy); end
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL timeout_noevent: got %0d events, required 0", got_q.size()); end
        send_frame(8'h23, 0, 0, 1);
        tick(10);
        checks++; if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            errors++; $display("FAIL timeout_next: got %0d events head %h, required 1 event %h", got_q.size(), got_q.size() > 0 ? got_q[0] : 10'h0, exp_q[0]);
        end
    endtask

    task automatic test_random();
        int  f0, nbad;
        bit  done;
        logic [7:0] b;
        bit  bp, bs;
        clear_queues();
        f0 = ferr_cnt; nbad = 0; done = 0;
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    case ($urandom_range(0, 9))
                        0:       b = 8'hE0;
                        1:       b = 8'hF0;
                        default: b = rand_make();
                    endcase
                    if (i == 5) b = 8'hE1;
                    bp = ($urandom_range(0, 9) == 0);
                    bs = !bp && ($urandom_range(0, 9) == 0);
                    if (bp || bs) nbad++;
                    send_frame(b, bp, bs, 1);
                end
                while (m_e1 > 0) send_frame(rand_make(), 0, 0, 1);
                done = 1;
            end
            while (!done) begin
                KeyReady = 1'($urandom_range(0, 1));
                tick(1);
            end
        join
        KeyReady = 1'b1;
        tick(20);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL random_count: got %0d events, required %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL random_event%0d: got %h, required %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (ferr_cnt - f0 != nbad) begin errors++; $display("FAIL random_ferr: got %0d, required %0d", ferr_cnt - f0, nbad); end
    endtask

    task automatic test_overflow();
        int o0;
        clear_queues();
        KeyReady = 1'b0;
        cap_en = 1; exp_ovf = 0;
        o0 = ovf_cnt;
        for (int i = 0; i < 5; i++) send_frame(rand_make(), 0, 0, 1);
        checks++; if (ovf_cnt - o0 != exp_ovf) begin errors++; $display("FAIL ovf_pulses: got %0d, required %0d", ovf_cnt - o0, exp_ovf); end
        checks++; if (KeyValid !== 1'b1) begin errors++; $display("FAIL ovf_valid: got %b, required 1", KeyValid); end
        KeyReady = 1'b1;
        tick(10);
        KeyReady = 1'b0;
        tick(2);
        cap_en = 0;
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL ovf_count: got %0d events, required %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_event%0d: got %h, required %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (KeyValid !== 1'b0) begin errors++; $display("FAIL ovf_drained: got %b, required 0", KeyValid); end
    endtask

    task automatic test_reset_midframe();
        clear_queues();
        KeyReady = 1'b0;
        send_frame(8'h15, 0, 0, 1);
        send_frame(8'h2B, 0, 0, 1);
        send_frame(8'hE0, 0, 0, 1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        RSTN = 1'b0;
        #2;
        checks++;
        if ({KeyCode, KeyExt, KeyBreak, KeyValid, FrameErr, Overflow, Busy} !== 14'h0) begin
            errors++; $display("FAIL midreset_outputs: got code=%h ext=%b brk=%b vld=%b ferr=%b ovf=%b busy=%b, required all 0",
                               KeyCode, KeyExt, KeyBreak, KeyValid, FrameErr, Overflow, Busy);
        end
`ifdef PS2_DIR_DECODE_EN
        checks++; if (Dir !== 2'b00) begin errors++; $display("FAIL midreset_dir: got %b, required 00", Dir); end
`endif
        PS2CLK = 1'b1; PS2Data = 1'b1;
        tick(5);
        RSTN = 1'b1;
        tick(2);
        clear_queues();
        m_ext = 0; m_brk = 0; m_e1 = 0;
        KeyReady = 1'b1;
        send_frame(8'h4D, 0, 0, 1);
        tick(10);
        checks++; if (got_q.size() != 1 || got_q[0] !== 10'h04D) begin
            errors++; $display("FAIL midreset_next: got %0d events head %h, required 1 event 04d", got_q.size(), got_q.size() > 0 ? got_q[0] : 10'h0);
        end
    endtask

`ifdef PS2_DIR_DECODE_EN
    task automatic test_dir();
        int d0;
        KeyReady = 1'b1;
        d0 = dirupd_cnt;
        send_frame(8'hE0, 0, 0, 1);
        send_frame(8'h6B, 0, 0, 1);
        tick(4);
        checks++; if (Dir !== 2'b10) begin errors++; $display("FAIL dir_left: got %b, required 10", Dir); end
        checks++; if (dirupd_cnt - d0 != 1) begin errors++; $display("FAIL dir_upd: got %0d pulses, required 1", dirupd_cnt - d0); end
        send_frame(8'hF0, 0, 0, 1);
        send_frame(8'h1D, 0, 0, 1);
        tick(4);
        checks++; if (Dir !== 2'b10 || dirupd_cnt - d0 != 1) begin errors++; $display("FAIL dir_break: got %b/%0d, required 10/1", Dir, dirupd_cnt - d0); end
        send_frame(8'h1C, 0, 0, 1);
        tick(4);
        checks++; if (Dir !== 2'b10 || dirupd_cnt - d0 != 1) begin errors++; $display("FAIL dir_same: got %b/%0d, required 10/1", Dir, dirupd_cnt - d0); end
        send_frame(8'h23, 0, 0, 1);
        tick(4);
        checks++; if (Dir !== 2'b11 || dirupd_cnt - d0 != 2) begin errors++; $display("FAIL dir_right: got %b/%0d, required 11/2", Dir, dirupd_cnt - d0); end
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_prefix();
        test_frame_errors();
        test_timeout();
        test_random();
        test_overflow();
        test_reset_midframe();
`ifdef PS2_DIR_DECODE_EN
        test_dir();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
